// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block.
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   MAX_NUM_IN         : largest supported channel count
//   clog2()            : ceiling log2, used for SEL_W sanity checks
package stream_mux_pkg;

  localparam int unsigned ARB_RR     = 0;
  localparam int unsigned ARB_FIXED  = 1;
  localparam int unsigned MAX_NUM_IN = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic for stream_mux_rr.
// Ports:
//   req_i     : request vector (one bit per channel)
//   ptr_i     : round-robin start index (ignored in fixed-priority mode)
//   gnt_oh_o  : one-hot grant, zero when no request
//   gnt_idx_o : index of the granted channel (0 when none)
//   gnt_any_o : some channel is granted
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_oh_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              gnt_any_o
);

  // Two passes: the first only looks at channels at or above ptr (or all of them in fixed mode),
  // the second catches the wrap-around to channels below ptr.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (!gnt_any_o && req_i[i] && (ARB_MODE == ARB_FIXED || i >= int'(ptr_i))) begin
        gnt_any_o   = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = SEL_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (!gnt_any_o && req_i[i]) begin
        gnt_any_o   = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with internal arbitration and one registered output slot
// (1-cycle latency, full throughput).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : per-channel handshake (in_ready one-hot or zero)
//   in_data               : channel i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready : output handshake
//   out_data, out_sel     : registered word and the channel it came from
//   xfer_cnt              : saturating count of output transfers (only with STREAM_MUX_RR_STATS_EN)
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
`ifdef STREAM_MUX_RR_STATS_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  if (NUM_IN < 1 || NUM_IN > MAX_NUM_IN || SEL_W < 1 || SEL_W < clog2(NUM_IN)) begin : g_bad_cfg
    $error("stream_mux_rr: unsupported NUM_IN/SEL_W combination");
  end

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [NUM_IN-1:0] gnt_oh;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              load_en;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_IN  (NUM_IN),
    .SEL_W   (SEL_W),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .req_i    (in_valid),
    .ptr_i    (ptr_q),
    .gnt_oh_o (gnt_oh),
    .gnt_idx_o(gnt_idx),
    .gnt_any_o(gnt_any)
  );

  // Ready-through: a slot being drained this cycle may reload in the same cycle.
  assign load_en  = !out_valid_q || out_ready;
  // Gated by rst_n so no handshake can complete while reset is held.
  assign in_ready = (load_en && rst_n) ? gnt_oh : '0;

  // One-hot mux: only the granted channel reaches the slot, others (even X) are masked.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (gnt_oh[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = sel_data;
        out_sel_d  = gnt_idx;
        if (ARB_MODE == ARB_RR) begin
          ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef STREAM_MUX_RR_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready && xfer_cnt_q != 16'hFFFF) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
